// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of
// {instruction, pc} pairs with fetch backpressure and branch flush.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instruction,
  input  logic [31:0]       in_pc,
  output logic              in_ready,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_instruction,
  output logic [31:0]       out_pc,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [63:0]       mem_q [DEPTH];
  logic [63:0]       mem_d [DEPTH];
  logic              push, pop;

  // Ready/valid come from registered count only, so no out_ready -> in_ready path.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  always_comb begin
    out_instruction = 32'd0;
    out_pc          = 32'd0;
    if (out_valid) begin
      out_instruction = mem_q[rd_ptr_q][63:32];
      out_pc          = mem_q[rd_ptr_q][31:0];
    end
  end

  always_comb begin
    push     = in_valid & in_ready & ~flush;
    pop      = out_valid & out_ready & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_instruction, in_pc};
        wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] model_q [$];

  fetch_queue #(.DEPTH(4), .ADDR_W(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_instruction(in_instruction), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_instruction(out_instruction), .out_pc(out_pc),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of pairs, updated from the inputs seen at each edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      automatic bit do_pop  = (model_q.size() != 0) && out_ready;
      automatic bit do_push = in_valid && (model_q.size() != 4);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({in_instruction, in_pc});
    end
  end

  always @(negedge clock) begin
    automatic logic [63:0] head = (model_q.size() != 0) ? model_q[0] : 64'd0;
    chk("cyc_count",     {29'd0, count},     32'(model_q.size()));
    chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
    chk("cyc_in_ready",  {31'd0, in_ready},  {31'd0, model_q.size() != 4});
    chk("cyc_out_instr", out_instruction,    head[63:32]);
    chk("cyc_out_pc",    out_pc,             head[31:0]);
    if (out_valid && out_instruction == 32'h12345678) begin
      chk("flushed_word_seen", out_instruction, 32'h0);
    end
  end

  // Apply inputs, let one rising edge take them, then settle just after it.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid = v; in_instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clock);
    #2;
  endtask

  task automatic head_is(input string name, input logic [31:0] ins, input logic [31:0] pc,
                         input int cnt);
    chk({name, "_instr"}, out_instruction, ins);
    chk({name, "_pc"}, out_pc, pc);
    chk({name, "_count"}, {29'd0, count}, 32'(cnt));
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_instruction = 0; in_pc = 0; out_ready = 0; flush = 0;
    #12 reset = 1'b0;
    @(posedge clock); #2;

    // Idle after reset
    head_is("rst", 32'h0, 32'h0, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Three pushes, then drain in order
    cycle(1, 32'hE3A01005, 32'd4, 0, 0);
    head_is("p1", 32'hE3A01005, 32'd4, 1);
    cycle(1, 32'hE2812003, 32'd8, 0, 0);
    cycle(1, 32'hE0823001, 32'd12, 0, 0);
    head_is("p3", 32'hE3A01005, 32'd4, 3);
    cycle(0, 32'h0, 32'h0, 1, 0);
    head_is("d1", 32'hE2812003, 32'd8, 2);
    cycle(0, 32'h0, 32'h0, 1, 0);
    head_is("d2", 32'hE0823001, 32'd12, 1);
    cycle(0, 32'h0, 32'h0, 1, 0);
    head_is("d3", 32'h0, 32'h0, 0);
    chk("d3_out_valid", {31'd0, out_valid}, 32'd0);

    // Fill to full, fifth word rejected, drain exactly four
    for (int i = 0; i < 4; i++) cycle(1, 32'h11110000 + i, 32'h40 + 4 * i, 0, 0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_count", {29'd0, count}, 32'd4);
    cycle(1, 32'hDEADBEEF, 32'h99, 0, 0);
    chk("full_count_after5", {29'd0, count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      head_is("drain", 32'h11110000 + i, 32'h40 + 4 * i, 4 - i);
      cycle(0, 32'h0, 32'h0, 1, 0);
    end
    head_is("drained", 32'h0, 32'h0, 0);

    // Pop at full does not admit a push in the same cycle
    for (int i = 0; i < 4; i++) cycle(1, 32'h22220000 + i, 32'h80 + 4 * i, 0, 0);
    cycle(1, 32'h2222FFFF, 32'hFC, 1, 0);
    head_is("popfull", 32'h22220001, 32'h84, 3);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);

    // Steady push+pop with one entry held; pointers wrap repeatedly
    cycle(1, 32'hC0000000, 32'h200, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cycle(1, 32'hC0000000 + k, 32'h200 + 4 * k, 1, 0);
      head_is("stream", 32'hC0000000 + k, 32'h200 + 4 * k, 1);
    end
    cycle(0, 32'h0, 32'h0, 1, 0);
    head_is("stream_end", 32'h0, 32'h0, 0);

    // Flush with a push and pop pending: both suppressed
    cycle(1, 32'hF0000001, 32'h2F0, 0, 0);
    cycle(1, 32'hF0000002, 32'h2F4, 0, 0);
    cycle(1, 32'h12345678, 32'h300, 1, 1);
    head_is("flush", 32'h0, 32'h0, 0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    cycle(1, 32'hABCD0001, 32'h304, 0, 0);
    head_is("post_flush", 32'hABCD0001, 32'h304, 1);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Asynchronous reset between edges with three entries held
    for (int i = 0; i < 3; i++) cycle(1, 32'h33330000 + i, 32'h400 + 4 * i, 0, 0);
    in_valid = 0;
    chk("pre_areset_count", {29'd0, count}, 32'd3);
    #1 reset = 1'b1;
    #1;
    head_is("areset", 32'h0, 32'h0, 0);
    chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_in_ready", {31'd0, in_ready}, 32'd1);
    #1 reset = 1'b0;
    @(posedge clock); #2;
    cycle(1, 32'h44440000, 32'h500, 0, 0);
    head_is("after_areset", 32'h44440000, 32'h500, 1);
    cycle(0, 32'h0, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
